// File: rtl/pc_stepper_pkg.sv
// Shared types and constants for the program-counter stepper and its button debouncer.
package pc_stepper_pkg;
  localparam int PC_WIDTH   = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } deb_state_t;
endpackage

// File: rtl/pc_stepper_button_debouncer.sv
// Synchronizes a raw active-low pushbutton and emits one pulse per stable press.
// Reusable for any board KEY; the FSM state is exposed for observation.
module button_debouncer
  import pc_stepper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  output logic       press,
  output deb_state_t state
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          pressed;

  assign pressed = ~sync[1];
  // Pulse is a decode of registered state and the registered synchronizer output.
  assign press   = (state == DEB_PRESS) && pressed && (cnt == LAST);

  // The synchronizer resets to "pressed" and armed stays low until a real release
  // has propagated, so a key held through reset never produces a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      cnt   <= '0;
      armed <= 1'b0;
      state <= IDLE;
    end else begin
      sync <= {sync[0], btn_n};
      if (!pressed) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (pressed && armed) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!pressed)         state <= IDLE;
          else if (cnt == LAST) state <= HELD;
          else                  cnt   <= cnt + CW'(1);
        end
        HELD: begin
          if (!pressed) begin
            state <= DEB_REL;
            cnt   <= '0;
          end
        end
        DEB_REL: begin
          if (pressed)          state <= HELD;
          else if (cnt == LAST) state <= IDLE;
          else                  cnt   <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/pc_stepper.sv
// Program-counter stage: advances PC on a debounced KEY press or a run-mode tick,
// applies taken branches and wraps at MAX_WORDS so the display stays within 00..99.
module pc_stepper
  import pc_stepper_pkg::*;
#(
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter int                   RUN_DIV         = 25000000,
  parameter logic [PC_WIDTH-1:0]  RESET_PC        = 32'h0,
  parameter int                   MAX_WORDS       = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_btn_n,
  input  logic                run_mode,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] PC,
  output logic                step_o,
  output logic                wrapped_o,
  output logic [15:0]         instr_count,
  output deb_state_t          deb_state
);
  localparam int RW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_DIV - 1);

  logic                btn_press;
  logic [RW-1:0]       run_cnt;
  logic                run_tick;
  logic                adv_req;
  logic [PC_WIDTH-1:0] nxt;
  logic                wrap;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (step_btn_n),
    .press (btn_press),
    .state (deb_state)
  );

  assign run_tick = run_mode && (run_cnt == RUN_LAST);
  assign adv_req  = run_mode ? run_tick : btn_press;
  assign nxt      = branch_taken ? (branch_target & ~32'h3) : (PC + 32'(WORD_BYTES));
  assign wrap     = nxt[PC_WIDTH-1:2] >= 30'(MAX_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (!run_mode || run_tick) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + RW'(1);
    end
  end

  // Halt wins over a request in the same cycle; the request is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC          <= RESET_PC;
      step_o      <= 1'b0;
      wrapped_o   <= 1'b0;
      instr_count <= 16'h0;
    end else begin
      step_o <= 1'b0;
      if (adv_req && !halt) begin
        step_o <= 1'b1;
        if (wrap) begin
          PC        <= RESET_PC;
          wrapped_o <= 1'b1;
        end else begin
          PC <= nxt;
        end
        if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'h1;
      end
    end
  end
endmodule

// File: tb/tb_pc_stepper.sv
// Directed and randomized checks of pc_stepper against a PC-arithmetic reference model.
module tb_pc_stepper;
  import pc_stepper_pkg::*;

  localparam int          DEB   = 4;
  localparam int          RDIV  = 8;
  localparam int          MAXW  = 100;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_btn_n = 1'b1;
  logic        run_mode = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] PC;
  logic        step_o;
  logic        wrapped_o;
  logic [15:0] instr_count;
  deb_state_t  deb_state;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_wrap;
  int          m_cnt;

  pc_stepper #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_DIV(RDIV),
    .RESET_PC(RPC),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .step_btn_n(step_btn_n),
    .run_mode(run_mode),
    .halt(halt),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .PC(PC),
    .step_o(step_o),
    .wrapped_o(wrapped_o),
    .instr_count(instr_count),
    .deb_state(deb_state)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: next PC from the architectural rules, with word-limit wrap.
  task automatic model_adv(logic bt, logic [31:0] tgt);
    logic [31:0] n;
    n = bt ? (tgt / 4) * 4 : m_pc + 32'd4;
    if ((n / 4) >= MAXW) begin
      m_pc   = RPC;
      m_wrap = 1'b1;
    end else begin
      m_pc = n;
    end
    if (m_cnt < 65535) m_cnt++;
    exp_q.push_back(m_pc);
  endtask

  task automatic model_reset();
    m_pc   = RPC;
    m_wrap = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // Sample after each active edge; every step_o pulse must match the next queued PC.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (step_o) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL step_unexpected observed=pulse expected=none pc=%h", PC);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("step_pc", PC, e);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic press(int hold);
    step_btn_n = 1'b0;
    repeat (hold) tick();
    step_btn_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic check_state(string tag);
    check({tag, "_pc"}, PC, m_pc);
    check({tag, "_wrap"}, 32'(wrapped_o), 32'(m_wrap));
    check({tag, "_cnt"}, 32'(instr_count), 32'(m_cnt));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_pc"}, PC, RPC);
    check({tag, "_step"}, 32'(step_o), 32'd0);
    check({tag, "_wrap"}, 32'(wrapped_o), 32'd0);
    check({tag, "_cnt"}, 32'(instr_count), 32'd0);
    check({tag, "_deb"}, 32'(deb_state), 32'(IDLE));
  endtask

  initial begin
    logic        bt;
    logic [31:0] tgt;
    logic        hl;
    int          n;

    model_reset();
    #2;
    check_reset_vals("reset");
    apply_reset();
    check_reset_vals("reset_rel");

    // Bouncy press: low 2, high 1, low 10 -> one update; bouncy release -> none.
    model_adv(1'b0, 32'h0);
    step_btn_n = 1'b0; repeat (2) tick();
    step_btn_n = 1'b1; tick();
    step_btn_n = 1'b0; repeat (10) tick();
    step_btn_n = 1'b1; tick();
    step_btn_n = 1'b0; tick();
    step_btn_n = 1'b1; repeat (12) tick();
    check_state("bouncy");
    check("bouncy_pc_abs", PC, 32'h4);

    // Run mode: 40 cycles -> 5 updates; button activity ignored.
    apply_reset();
    repeat (5) model_adv(1'b0, 32'h0);
    run_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step_btn_n = !(i >= 5 && i < 20);
      tick();
    end
    run_mode = 1'b0;
    step_btn_n = 1'b1;
    repeat (10) tick();
    check_state("run");
    check("run_pc_abs", PC, 32'h14);

    // Branch with unaligned target.
    apply_reset();
    branch_taken = 1'b1;
    branch_target = 32'h10; model_adv(1'b1, 32'h10); press(10);
    branch_target = 32'h3B; model_adv(1'b1, 32'h3B); press(10);
    branch_taken = 1'b0;
    check_state("branch");
    check("branch_pc_abs", PC, 32'h38);

    // Wrap at word 99, sticky flag, branch beyond the limit.
    branch_taken = 1'b1; branch_target = 32'h18C;
    model_adv(1'b1, 32'h18C); press(10);
    branch_taken = 1'b0;
    model_adv(1'b0, 32'h0); press(10);
    check("wrap_pc_abs", PC, 32'h0);
    check("wrap_flag_abs", 32'(wrapped_o), 32'd1);
    model_adv(1'b0, 32'h0); press(10);
    model_adv(1'b0, 32'h0); press(10);
    branch_taken = 1'b1; branch_target = 32'h400;
    model_adv(1'b1, 32'h400); press(10);
    branch_taken = 1'b0;
    check_state("wrap");

    // Halt drops the request; no update after halt clears until a new press.
    halt = 1'b1; press(10);
    halt = 1'b0; repeat (12) tick();
    check_state("halt");
    model_adv(1'b0, 32'h0); press(10);
    check_state("halt_after");

    // Reset during DEB_PRESS with the key kept held across reset release.
    step_btn_n = 1'b0;
    repeat (4) tick();
    check("mid_deb_state", 32'(deb_state), 32'(DEB_PRESS));
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_vals("rst_deb");
    tick();
    #2 rst_n = 1'b1;
    repeat (15) tick();
    check_state("held_thru_rst");
    step_btn_n = 1'b1; repeat (6) tick();
    model_adv(1'b0, 32'h0); press(10);
    check_state("repress");

    // Reset in the middle of a run interval restarts the divider.
    run_mode = 1'b1;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_vals("rst_run");
    run_mode = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    repeat (4) tick();
    run_mode = 1'b1;
    model_adv(1'b0, 32'h0);
    repeat (RDIV) tick();
    run_mode = 1'b0;
    repeat (3) tick();
    check_state("run_restart");

    // Randomized presses with random branches, targets and halts.
    for (int k = 0; k < 12; k++) begin
      bt  = 1'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h1FF));
      hl  = ($urandom_range(0, 3) == 0);
      branch_taken = bt; branch_target = tgt; halt = hl;
      if (!hl) model_adv(bt, tgt);
      press(int'($urandom_range(8, 14)));
      halt = 1'b0; branch_taken = 1'b0;
      check_state("rand_press");
    end

    // Randomized run bursts, including partial intervals that must be discarded.
    for (int k = 0; k < 3; k++) begin
      n = int'($urandom_range(8, 40));
      for (int j = 0; j < n / RDIV; j++) model_adv(1'b0, 32'h0);
      run_mode = 1'b1;
      repeat (n) tick();
      run_mode = 1'b0;
      repeat (3) tick();
      check_state("rand_run");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
